// File: rtl/udp_rx_controller.sv
// UDP receive controller: parses the 8-byte big-endian UDP header, then passes the payload
// straight through with a one-cycle CHECK bubble between header and payload.
module udp_rx_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] udp_length,
    output logic [15:0] checksum,
    output logic        hdr_valid,
    output logic        len_err,
    output logic        counter_rst,
    output logic        counter_enable,
    output logic [15:0] counter_length,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {StHdr, StCheck, StPayload} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_rdy_en;
    logic [2:0]  r_idx;
    logic [15:0] r_sh_src;
    logic [15:0] r_sh_dst;
    logic [15:0] r_sh_len;
    logic [7:0]  r_sh_csum_hi;
    logic [15:0] r_src_port;
    logic [15:0] r_dst_port;
    logic [15:0] r_udp_length;
    logic [15:0] r_checksum;
    logic [15:0] r_counter_length;
    logic [15:0] r_remaining;
    logic [15:0] r_pkt_count;
    logic [15:0] r_err_count;

    logic w_s_xfer;
    logic w_hdr_done;
    logic w_len_short;
    logic w_len_empty;
    logic w_pay_xfer;
    logic w_last_xfer;

    assign w_s_xfer    = s_valid && s_ready;
    assign w_hdr_done  = (r_state == StHdr) && w_s_xfer && (r_idx == 3'd7);
    assign w_len_short = r_udp_length < 16'd8;
    assign w_len_empty = r_udp_length == 16'd8;
    assign w_pay_xfer  = (r_state == StPayload) && w_s_xfer;
    assign w_last_xfer = w_pay_xfer && (r_remaining == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StHdr;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StHdr:     if (w_hdr_done) w_state_next = StCheck;
            StCheck:   w_state_next = (w_len_short || w_len_empty) ? StHdr : StPayload;
            StPayload: if (w_last_xfer) w_state_next = StHdr;
            default:   w_state_next = StHdr;
        endcase
    end

    always_comb begin
        s_ready        = 1'b0;
        m_data         = 8'h00;
        m_valid        = 1'b0;
        m_last         = 1'b0;
        hdr_valid      = 1'b0;
        len_err        = 1'b0;
        counter_rst    = 1'b0;
        counter_enable = 1'b0;
        unique case (r_state)
            StHdr: s_ready = r_rdy_en;
            StCheck: begin
                hdr_valid   = 1'b1;
                counter_rst = 1'b1;
                len_err     = w_len_short;
            end
            StPayload: begin
                // Zero-latency pass-through: the source sees downstream backpressure directly.
                m_data         = s_data;
                m_valid        = s_valid;
                s_ready        = m_ready;
                m_last         = s_valid && (r_remaining == 16'd1);
                counter_enable = s_valid && m_ready;
            end
            default: s_ready = 1'b0;
        endcase
    end

    // Holds s_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx            <= 3'd0;
            r_sh_src         <= 16'h0000;
            r_sh_dst         <= 16'h0000;
            r_sh_len         <= 16'h0000;
            r_sh_csum_hi     <= 8'h00;
            r_src_port       <= 16'h0000;
            r_dst_port       <= 16'h0000;
            r_udp_length     <= 16'h0000;
            r_checksum       <= 16'h0000;
            r_counter_length <= 16'h0000;
            r_remaining      <= 16'h0000;
            r_pkt_count      <= 16'h0000;
            r_err_count      <= 16'h0000;
        end else begin
            if ((r_state == StHdr) && w_s_xfer) begin
                r_idx <= r_idx + 3'd1;
                unique case (r_idx)
                    3'd0: r_sh_src[15:8] <= s_data;
                    3'd1: r_sh_src[7:0]  <= s_data;
                    3'd2: r_sh_dst[15:8] <= s_data;
                    3'd3: r_sh_dst[7:0]  <= s_data;
                    3'd4: r_sh_len[15:8] <= s_data;
                    3'd5: r_sh_len[7:0]  <= s_data;
                    3'd6: r_sh_csum_hi   <= s_data;
                    default: ;
                endcase
            end
            if (w_hdr_done) begin
                r_src_port       <= r_sh_src;
                r_dst_port       <= r_sh_dst;
                r_udp_length     <= r_sh_len;
                r_checksum       <= {r_sh_csum_hi, s_data};
                r_counter_length <= (r_sh_len >= 16'd8) ? (r_sh_len - 16'd8) : 16'h0000;
            end
            if (r_state == StCheck) begin
                if (w_len_short) begin
                    r_err_count <= r_err_count + 16'd1;
                end else if (w_len_empty) begin
                    r_pkt_count <= r_pkt_count + 16'd1;
                end else begin
                    r_remaining <= r_udp_length - 16'd8;
                end
            end
            if (w_pay_xfer) begin
                r_remaining <= r_remaining - 16'd1;
                if (w_last_xfer) r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign src_port       = r_src_port;
    assign dst_port       = r_dst_port;
    assign udp_length     = r_udp_length;
    assign checksum       = r_checksum;
    assign counter_length = r_counter_length;
    assign pkt_count      = r_pkt_count;
    assign err_count      = r_err_count;

endmodule

// File: tb/tb_udp_rx_controller.sv
// Scoreboard bench for udp_rx_controller: drivers push expected header/payload items into
// queues and a negedge monitor checks them whenever the DUT presents them.
module tb_udp_rx_controller;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_length;
    logic [15:0] checksum;
    logic        hdr_valid;
    logic        len_err;
    logic        counter_rst;
    logic        counter_enable;
    logic [15:0] counter_length;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    udp_rx_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .src_port       (src_port),
        .dst_port       (dst_port),
        .udp_length     (udp_length),
        .checksum       (checksum),
        .hdr_valid      (hdr_valid),
        .len_err        (len_err),
        .counter_rst    (counter_rst),
        .counter_enable (counter_enable),
        .counter_length (counter_length),
        .pkt_count      (pkt_count),
        .err_count      (err_count)
    );

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [15:0] csum;
    } hdr_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } pay_t;

    hdr_t hdr_q[$];
    pay_t pay_q[$];
    bit   pat_q[$];

    int checks = 0;
    int errors = 0;
    int ce_cnt = 0;
    int le_cnt = 0;
    int ce0;
    int le0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares against queue heads; stalled beats are checked every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid) begin
                if (pay_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_m_valid actual=1 required=0 data=%0h", m_data);
                end else begin
                    chk("m_data", {24'h0, m_data}, {24'h0, pay_q[0].data});
                    chk("m_last", {31'h0, m_last}, {31'h0, pay_q[0].last});
                    if (m_ready) void'(pay_q.pop_front());
                end
            end
            if (hdr_valid) begin
                if (hdr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hdr_valid actual=1 required=0");
                end else begin
                    hdr_t h;
                    logic [15:0] cl;
                    h  = hdr_q.pop_front();
                    cl = (h.len >= 16'd8) ? h.len - 16'd8 : 16'h0000;
                    chk("src_port", {16'h0, src_port}, {16'h0, h.src});
                    chk("dst_port", {16'h0, dst_port}, {16'h0, h.dst});
                    chk("udp_length", {16'h0, udp_length}, {16'h0, h.len});
                    chk("checksum", {16'h0, checksum}, {16'h0, h.csum});
                    chk("counter_length", {16'h0, counter_length}, {16'h0, cl});
                    chk("len_err", {31'h0, len_err}, {31'h0, (h.len < 16'd8)});
                    chk("counter_rst", {31'h0, counter_rst}, 32'd1);
                end
            end
            if (counter_enable) ce_cnt++;
            if (len_err) le_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit pay);
        int  t;
        bit  done;
        t    = 0;
        done = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        while (!done) begin
            if (pay) m_ready = (pat_q.size() > 0) ? pat_q.pop_front() : 1'b1;
            @(negedge clk);
            if (s_ready) done = 1'b1;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=no_ready required=ready byte=%0h", b);
                done = 1'b1;
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic send_hdr(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input logic [15:0] csum);
        hdr_t h;
        h.src  = src;
        h.dst  = dst;
        h.len  = len;
        h.csum = csum;
        hdr_q.push_back(h);
        send_byte(src[15:8], 1'b0);
        send_byte(src[7:0], 1'b0);
        send_byte(dst[15:8], 1'b0);
        send_byte(dst[7:0], 1'b0);
        send_byte(len[15:8], 1'b0);
        send_byte(len[7:0], 1'b0);
        send_byte(csum[15:8], 1'b0);
        send_byte(csum[7:0], 1'b0);
    endtask

    // Sends the first n_send bytes of an n_total-byte payload starting at value base.
    task automatic send_pay(input int n_total, input int n_send, input logic [7:0] base);
        for (int i = 0; i < n_send; i++) begin
            pay_t p;
            p.data = base + 8'(i);
            p.last = (i == n_total - 1);
            pay_q.push_back(p);
            send_byte(p.data, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_s_ready", {31'h0, s_ready}, 32'd0);
        chk("rst_m_valid", {31'h0, m_valid}, 32'd0);
        chk("rst_pkt_count", {16'h0, pkt_count}, 32'd0);
        chk("rst_err_count", {16'h0, err_count}, 32'd0);
        chk("rst_src_port", {16'h0, src_port}, 32'd0);
        chk("rst_counter_length", {16'h0, counter_length}, 32'd0);
        chk("rst_strobes", {28'h0, hdr_valid, len_err, counter_rst, counter_enable}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_ready_before_edge", {31'h0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("s_ready_after_edge", {31'h0, s_ready}, 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        m_ready = 1'b1;
        #2;
        pulse_reset();

        // Basic 3-byte packet.
        ce0 = ce_cnt;
        send_hdr(16'h1234, 16'h0050, 16'h000B, 16'hBEEF);
        send_pay(3, 3, 8'hA0);
        idle(3);
        chk("t1_pkt_count", {16'h0, pkt_count}, 32'd1);
        chk("t1_counter_length", {16'h0, counter_length}, 32'd3);
        chk("t1_ce_pulses", ce_cnt - ce0, 32'd3);

        // Same packet with downstream stalls.
        ce0 = ce_cnt;
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1};
        send_hdr(16'h1234, 16'h0050, 16'h000B, 16'hBEEF);
        send_pay(3, 3, 8'hA0);
        idle(3);
        chk("t2_pkt_count", {16'h0, pkt_count}, 32'd2);
        chk("t2_ce_pulses", ce_cnt - ce0, 32'd3);

        // Short length: error, no payload.
        le0 = le_cnt;
        send_hdr(16'h0101, 16'h0202, 16'h0005, 16'h0303);
        idle(3);
        chk("t3_err_count", {16'h0, err_count}, 32'd1);
        chk("t3_len_err_pulses", le_cnt - le0, 32'd1);
        chk("t3_pkt_count", {16'h0, pkt_count}, 32'd2);

        // Empty payload, then a normal packet.
        send_hdr(16'hAAAA, 16'hBBBB, 16'h0008, 16'hCCCC);
        idle(3);
        chk("t4_pkt_count", {16'h0, pkt_count}, 32'd3);
        send_hdr(16'h0F0F, 16'hF0F0, 16'h000A, 16'h5A5A);
        send_pay(2, 2, 8'h10);
        idle(3);
        chk("t4b_pkt_count", {16'h0, pkt_count}, 32'd4);
        chk("t4b_src_hold", {16'h0, src_port}, 32'h0F0F);

        // Reset after 2 of 5 payload bytes.
        send_hdr(16'h4444, 16'h5555, 16'h000D, 16'h6666);
        send_pay(5, 2, 8'h30);
        pulse_reset();
        send_hdr(16'h1234, 16'h0050, 16'h000B, 16'hBEEF);
        send_pay(3, 3, 8'hA0);
        idle(3);
        chk("t5_pkt_count", {16'h0, pkt_count}, 32'd1);
        chk("t5_src_port", {16'h0, src_port}, 32'h1234);
        chk("t5_err_count", {16'h0, err_count}, 32'd0);

        // Counter wrap with 65536 empty packets.
        pulse_reset();
        for (int i = 0; i < 65536; i++) begin
            send_hdr(16'h0000, 16'h0000, 16'h0008, 16'h0000);
            if (i == 65534) begin
                idle(2);
                chk("t6_pkt_count_max", {16'h0, pkt_count}, 32'hFFFF);
            end
        end
        idle(3);
        chk("t6_pkt_count_wrap", {16'h0, pkt_count}, 32'd0);

        chk("hdr_q_empty", hdr_q.size(), 32'd0);
        chk("pay_q_empty", pay_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_rx_controller.md
UDP_RX_CONTROLLER -- requirements
Module: udp_rx_controller

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all logic is rising-edge.
REQ-002 The block SHALL have the port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port `s_data`, input, 8 bits: inbound byte stream (UDP header followed by payload).
REQ-004 The block SHALL have the port `s_valid`, input, 1 bit: `s_data` valid.
REQ-005 The block SHALL have the port `s_ready`, output, 1 bit: block accepts `s_data`.
REQ-006 The block SHALL have the port `m_data`, output, 8 bits: payload byte out.
REQ-007 The block SHALL have the port `m_valid`, output, 1 bit: `m_data` valid.
REQ-008 The block SHALL have the port `m_ready`, input, 1 bit: downstream accepts `m_data`.
REQ-009 The block SHALL have the port `m_last`, output, 1 bit: current `m_data` is the final payload byte.
REQ-010 The block SHALL have the ports `src_port`, `dst_port`, `udp_length` and `checksum`, each an output of 16 bits: captured header fields.
REQ-011 The block SHALL have the port `hdr_valid`, output, 1 bit: one-cycle pulse when the header fields are updated.
REQ-012 The block SHALL have the port `len_err`, output, 1 bit: one-cycle pulse when `udp_length` < 8.
REQ-013 The block SHALL have the ports `counter_rst` and `counter_enable`, outputs of 1 bit each: byte-counter sequencing controls.
REQ-014 The block SHALL have the port `counter_length`, output, 16 bits: payload length for the byte counter.
REQ-015 The block SHALL have the ports `pkt_count` and `err_count`, outputs of 16 bits each: statistics counters.

Function
REQ-016 The state machine SHALL have exactly three states: HDR, CHECK and PAYLOAD; the reset state SHALL be HDR.
REQ-017 A transfer SHALL occur on a cycle where valid && ready; nothing else advances the data path.
REQ-018 In HDR, `s_ready` SHALL be 1 and `m_valid` SHALL be 0; the block SHALL accept 8 header bytes, counted by a 3-bit index.
REQ-019 Header bytes SHALL be big-endian, in the order src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], csum[15:8], csum[7:0].
REQ-020 The header fields SHALL be held in shadow registers and copied to the outputs on the 8th header transfer; the outputs SHALL hold their value until the next header completes.
REQ-021 On the 8th header transfer, the next state SHALL be CHECK, and `hdr_valid` SHALL pulse in the first CHECK cycle.
REQ-022 CHECK SHALL last exactly one cycle with `s_ready` = 0 and `m_valid` = 0, during which `counter_rst` = 1.
REQ-023 In CHECK, if `udp_length` < 8: `len_err` SHALL pulse, `err_count` SHALL increment, and the next state SHALL be HDR.
REQ-024 In CHECK, if `udp_length` == 8 (empty payload): `pkt_count` SHALL increment and the next state SHALL be HDR, with no `m_valid`.
REQ-025 In CHECK, if `udp_length` > 8: `remaining` SHALL be loaded with `udp_length` - 8 (16-bit, no underflow possible) and the next state SHALL be PAYLOAD.
REQ-026 `counter_length` SHALL equal `udp_length` - 8 when `udp_length` >= 8 and 0 otherwise; it SHALL be registered and valid from the CHECK cycle onward.
REQ-027 In PAYLOAD, `m_data` = `s_data`, `m_valid` = `s_valid` and `s_ready` = `m_ready`, all combinational with zero latency and no skid buffer.
REQ-028 `m_last` SHALL be `m_valid` && (`remaining` == 1).
REQ-029 On each PAYLOAD transfer, `remaining` SHALL decrement and `counter_enable` SHALL be 1 for that cycle (0 otherwise).
REQ-030 The transfer with `m_last` = 1 SHALL increment `pkt_count`, and the next state SHALL be HDR.
REQ-031 A backpressure stall (`m_ready` = 0) SHALL hold `m_data`, `m_valid` and `m_last` stable as long as the source holds its data; no bytes SHALL be dropped or duplicated.
REQ-032 `pkt_count` and `err_count` SHALL be 16-bit and wrap from 0xFFFF to 0x0000 without saturation.
REQ-033 The block SHALL not support back-to-back header-to-payload without CHECK; the one-cycle bubble per packet is required.

Reset
REQ-034 While `rst_n` = 0, asynchronously: state = HDR, header index = 0, `remaining` = 0, all header outputs = 0, `counter_length` = 0, `pkt_count` = 0, `err_count` = 0.
REQ-035 While `rst_n` = 0, all pulse/strobe outputs (`hdr_valid`, `len_err`, `counter_rst`, `counter_enable`, `m_valid`, `m_last`) SHALL be 0, and `s_ready` SHALL be 0.
REQ-036 `s_ready` SHALL be 1 from the first clock edge after reset release.
REQ-037 A reset asserted mid-packet SHALL abandon the packet without a count increment; the next accepted byte after release SHALL be treated as header byte 0.

Verification
REQ-038 The bench SHALL cover: header 0x1234, 0x0050, 0x000B, 0xBEEF, 3 payload bytes, `m_ready` = 1 -> `hdr_valid` pulse, fields match, `counter_length` = 3, `m_last` on the 3rd byte, `pkt_count` = 1.
REQ-039 The bench SHALL cover: the same packet with `m_ready` toggling 1,0,0,1 -> identical output byte sequence, `m_last` stable during the stall, 3 `counter_enable` pulses total.
REQ-040 The bench SHALL cover: `udp_length` = 0x0005 -> `len_err` pulse, `err_count` = 1, `m_valid` never asserted, and the next byte is parsed as a new header.
REQ-041 The bench SHALL cover: `udp_length` = 0x0008 -> `hdr_valid`, no `m_valid`, `pkt_count` +1, and the next packet parses correctly.
REQ-042 The bench SHALL cover: `rst_n` pulsed low after 2 of 5 payload bytes -> all outputs at reset values, `pkt_count` = 0, and a following clean packet is parsed correctly.
REQ-043 The bench SHALL cover: 65536 empty packets -> `pkt_count` wraps to 0x0000.
